// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, register-index width, well-known
// register numbers and the ALU operation encoding used downstream of the register file.
package core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 2;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: x0 / out-of-range masking plus an
// optional write-through mux that forwards the in-flight writeback value.
module regfile_read_port #(
   parameter int XLEN   = core_pkg::XLEN,
   parameter int NREGS  = 32,
   parameter int ADDR_W = core_pkg::REG_ADDR_W,
   parameter int BYPASS = 0
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   regs_i [NREGS],
   input  logic              fwd_en_i,
   input  logic [ADDR_W-1:0] fwd_addr_i,
   input  logic [XLEN-1:0]   fwd_data_i,
   output logic [XLEN-1:0]   data_o
);
   import core_pkg::*;

   localparam logic [ADDR_W:0] NREGS_W = NREGS[ADDR_W:0];

   logic addr_live;

   assign addr_live = (addr_i != ADDR_W'(REG_ZERO)) && ({1'b0, addr_i} < NREGS_W);

   always_comb begin
      data_o = '0;
      if (addr_live) begin
         // fwd_en_i already excludes reset, so a write that reset will drop is never forwarded
         if ((BYPASS != 0) && fwd_en_i && (fwd_addr_i == addr_i)) begin
            data_o = fwd_data_i;
         end else begin
            data_o = regs_i[addr_i];
         end
      end
   end

endmodule

// File: rtl/register_file.sv
// Integer register file x0..x31: two operand read ports, one debug read port,
// one synchronous writeback port and a committed-write counter.
module register_file #(
   parameter int          XLEN    = core_pkg::XLEN,
   parameter int          NREGS   = 32,
   parameter int          ADDR_W  = core_pkg::REG_ADDR_W,
   parameter int          BYPASS  = 0,
   parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [XLEN-1:0]   rd_wdata,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [XLEN-1:0]   dbg_data,
   output logic [31:0]       wr_count
);
   import core_pkg::*;

   localparam logic [ADDR_W:0] NREGS_W = NREGS[ADDR_W:0];

   logic [XLEN-1:0] regs_q    [1:NREGS-1];
   logic [XLEN-1:0] regs_view [NREGS];
   logic [31:0]     wr_count_q;
   logic [31:0]     wr_count_d;
   logic            fwd_en;
   logic            wr_ok;

   // Writes to x0 or to indices past the array are dropped before they can touch state
   assign fwd_en = reg_write && !rst;
   assign wr_ok  = fwd_en && (rd_addr != ADDR_W'(REG_ZERO)) && ({1'b0, rd_addr} < NREGS_W);

   always_comb begin
      regs_view[0] = '0;
      for (int i = 1; i < NREGS; i++) begin
         regs_view[i] = regs_q[i];
      end
   end

   always_comb begin
      wr_count_d = wr_count_q;
      if (wr_ok) begin
         wr_count_d = wr_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= (i == REG_SP) ? XLEN'(SP_INIT) : '0;
         end
         wr_count_q <= '0;
      end else begin
         if (wr_ok) begin
            regs_q[rd_addr] <= rd_wdata;
         end
         wr_count_q <= wr_count_d;
      end
   end

   regfile_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
   ) u_rs1 (
      .addr_i     (rs1_addr),
      .regs_i     (regs_view),
      .fwd_en_i   (fwd_en),
      .fwd_addr_i (rd_addr),
      .fwd_data_i (rd_wdata),
      .data_o     (rs1_data)
   );

   regfile_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
   ) u_rs2 (
      .addr_i     (rs2_addr),
      .regs_i     (regs_view),
      .fwd_en_i   (fwd_en),
      .fwd_addr_i (rd_addr),
      .fwd_data_i (rd_wdata),
      .data_o     (rs2_data)
   );

   // Debug/trace port always shows committed state, never the in-flight write
   regfile_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(0)
   ) u_dbg (
      .addr_i     (dbg_addr),
      .regs_i     (regs_view),
      .fwd_en_i   (fwd_en),
      .fwd_addr_i (rd_addr),
      .fwd_data_i (rd_wdata),
      .data_o     (dbg_data)
   );

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one BYPASS=0 and one BYPASS=1 instance share stimulus
// and are compared against an array-based architectural model.
module tb_register_file;

   localparam int          XLEN   = 32;
   localparam int          NREGS  = 32;
   localparam int          ADDR_W = 5;
   localparam logic [31:0] SP     = 32'h0000_3FF0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              reg_write;
   logic [ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr, dbg_addr;
   logic [XLEN-1:0]   rd_wdata;

   logic [XLEN-1:0] r1_b0, r2_b0, dbg_b0;
   logic [31:0]     cnt_b0;
   logic [XLEN-1:0] r1_b1, r2_b1, dbg_b1;
   logic [31:0]     cnt_b1;

   register_file #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(0), .SP_INIT(SP)) u_dut_b0 (
      .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(r1_b0), .rs2_data(r2_b0), .reg_write(reg_write), .rd_addr(rd_addr),
      .rd_wdata(rd_wdata), .dbg_addr(dbg_addr), .dbg_data(dbg_b0), .wr_count(cnt_b0)
   );

   register_file #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(1), .SP_INIT(SP)) u_dut_b1 (
      .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(r1_b1), .rs2_data(r2_b1), .reg_write(reg_write), .rd_addr(rd_addr),
      .rd_wdata(rd_wdata), .dbg_addr(dbg_addr), .dbg_data(dbg_b1), .wr_count(cnt_b1)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [XLEN-1:0] mreg [NREGS];
   logic [31:0]     mcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) mreg[i] = '0;
      mreg[2] = SP;
      mcnt    = '0;
   endtask

   function automatic logic [XLEN-1:0] ref_rd(input logic [ADDR_W-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && reg_write && !rst && rd_addr == a) return rd_wdata;
      return mreg[a];
   endfunction

   task automatic check_all(input string tag);
      #1;
      chk({tag, " rs1 b0"}, r1_b0, ref_rd(rs1_addr, 1'b0));
      chk({tag, " rs2 b0"}, r2_b0, ref_rd(rs2_addr, 1'b0));
      chk({tag, " dbg b0"}, dbg_b0, ref_rd(dbg_addr, 1'b0));
      chk({tag, " cnt b0"}, cnt_b0, mcnt);
      chk({tag, " rs1 b1"}, r1_b1, ref_rd(rs1_addr, 1'b1));
      chk({tag, " rs2 b1"}, r2_b1, ref_rd(rs2_addr, 1'b1));
      chk({tag, " dbg b1"}, dbg_b1, ref_rd(dbg_addr, 1'b0));
      chk({tag, " cnt b1"}, cnt_b1, mcnt);
   endtask

   // Check current-cycle outputs, then clock and advance the model with the same inputs
   task automatic cycle(input string tag);
      check_all(tag);
      @(posedge clk);
      if (rst) model_reset();
      else if (reg_write && rd_addr != 0) begin
         mreg[rd_addr] = rd_wdata;
         mcnt          = mcnt + 32'd1;
      end
      #1;
   endtask

   task automatic sweep_reset_state(input string tag);
      reg_write = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         rs1_addr = ADDR_W'(i);
         rs2_addr = ADDR_W'(NREGS - 1 - i);
         dbg_addr = ADDR_W'(i);
         #1;
         chk({tag, " rs1"}, r1_b0, (i == 2) ? SP : 32'h0);
         chk({tag, " rs2"}, r2_b1, ((NREGS - 1 - i) == 2) ? SP : 32'h0);
         chk({tag, " dbg"}, dbg_b1, (i == 2) ? SP : 32'h0);
      end
      chk({tag, " cnt b0"}, cnt_b0, 32'h0);
      chk({tag, " cnt b1"}, cnt_b1, 32'h0);
   endtask

   initial begin
      rst = 1'b1; reg_write = 1'b0; rd_addr = '0; rd_wdata = '0;
      rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
      @(posedge clk); #1;
      model_reset();
      rst = 1'b0;
      sweep_reset_state("reset");

      reg_write = 1'b1; rd_addr = 5'd5; rd_wdata = 32'h5;
      cycle("wr x5");
      rd_addr = 5'd6; rd_wdata = 32'h4;
      cycle("wr x6");
      reg_write = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
      #1;
      chk("alu and", r1_b0 & r2_b0, 32'h4);
      chk("alu add", r1_b0 + r2_b0, 32'h9);
      chk("cnt after 2 writes", cnt_b0, 32'd2);

      reg_write = 1'b1; rd_addr = 5'd0; rd_wdata = 32'hDEAD_BEEF; rs1_addr = 5'd0; rs2_addr = 5'd0;
      #1;
      chk("x0 same-cycle b1", r1_b1, 32'h0);
      chk("x0 same-cycle b0", r1_b0, 32'h0);
      cycle("x0 write");
      reg_write = 1'b0;
      #1;
      chk("x0 after edge", r1_b1, 32'h0);
      chk("x0 cnt unchanged", cnt_b1, 32'd2);

      reg_write = 1'b1; rd_addr = 5'd7; rd_wdata = 32'h7;
      cycle("wr x7=7");
      rd_wdata = 32'h9; rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
      #1;
      chk("raw b0 rs1 pre", r1_b0, 32'h7);
      chk("raw b0 rs2 pre", r2_b0, 32'h7);
      chk("raw b1 rs1 fwd", r1_b1, 32'h9);
      chk("raw b1 rs2 fwd", r2_b1, 32'h9);
      chk("raw b1 dbg pre", dbg_b1, 32'h7);
      cycle("raw x7");
      reg_write = 1'b0;
      #1;
      chk("raw b0 rs1 post", r1_b0, 32'h9);
      chk("raw b1 dbg post", dbg_b1, 32'h9);

      rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd3; rd_wdata = 32'h1234; rs1_addr = 5'd3;
      #1;
      chk("rst fwd blocked b1", r1_b1, 32'h0);
      cycle("rst vs write");
      rst = 1'b0; reg_write = 1'b0;
      #1;
      chk("rst vs write x3", r1_b0, 32'h0);
      chk("rst vs write cnt", cnt_b0, 32'h0);

      reg_write = 1'b1;
      for (int i = 1; i < NREGS; i++) begin
         rd_addr = ADDR_W'(i); rd_wdata = 32'(i);
         cycle("fill");
      end
      reg_write = 1'b0; dbg_addr = 5'd31;
      #1;
      chk("fill x31", dbg_b0, 32'd31);
      chk("fill cnt", cnt_b1, 32'd31);
      rst = 1'b1;
      cycle("mid reset");
      rst = 1'b0;
      sweep_reset_state("mid reset");
      reg_write = 1'b1; rd_addr = 5'd9; rd_wdata = 32'hA5A5_0009; rs1_addr = 5'd9;
      cycle("post-reset write");
      reg_write = 1'b0;
      #1;
      chk("post-reset x9", r1_b0, 32'hA5A5_0009);
      chk("post-reset cnt", cnt_b0, 32'd1);

      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 39) == 0);
         reg_write = $urandom_range(0, 1);
         rd_addr   = ADDR_W'($urandom_range(0, NREGS - 1));
         rd_wdata  = $urandom;
         rs1_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : ADDR_W'($urandom_range(0, NREGS - 1));
         rs2_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : ADDR_W'($urandom_range(0, NREGS - 1));
         dbg_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : ADDR_W'($urandom_range(0, NREGS - 1));
         cycle("rand");
      end
      rst = 1'b0; reg_write = 1'b0;
      check_all("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
